// File: rtl/pwm_burst_gen.sv
// pwm_burst_gen
//   Takes the count of the upstream free-running up-counter and turns it into
//   a burst of PWM periods. A start request arms the block; the burst begins
//   at the next counter period boundary and runs for nburst full periods. In
//   each period pwm_out is high while the count is below the latched duty.
//   stop aborts a burst at any time.
//
// Ports
//   clk      in   1           rising-edge system clock
//   rs       in   1           synchronous reset, active-high
//   cnt_in   in   CNT_W       upstream count (+1 per clk, wraps)
//   duty     in   CNT_W+1     high cycles per period, 0..2**CNT_W, taken at start
//   nburst   in   BURST_W     periods per burst, taken at start (0 = ignored)
//   start    in   1           one-cycle burst request
//   stop     in   1           abort the current burst
//   pwm_out  out  1           registered PWM output
//   busy     out  1           burst armed or running
//   done     out  1           one-cycle pulse on normal completion
//   per_cnt  out  BURST_W     periods completed in the current/last burst
module pwm_burst_gen #(
    parameter int CNT_W   = 4,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rs,
    input  logic [CNT_W-1:0]   cnt_in,
    input  logic [CNT_W:0]     duty,
    input  logic [BURST_W-1:0] nburst,
    input  logic               start,
    input  logic               stop,
    output logic               pwm_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] per_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [BURST_W-1:0] ONE_B  = BURST_W'(1);
    localparam logic [BURST_W-1:0] ZERO_B = {BURST_W{1'b0}};
    localparam logic [CNT_W-1:0]   ZERO_C = {CNT_W{1'b0}};

    state_t               state_r;
    state_t               next_state_s;
    logic [CNT_W-1:0]     cnt_d_r;
    logic [CNT_W:0]       duty_r;
    logic [BURST_W-1:0]   nburst_r;
    logic [BURST_W-1:0]   per_cnt_r;
    logic [BURST_W-1:0]   per_cnt_next_s;
    logic                 pwm_r;
    logic                 pwm_next_s;
    logic                 load_s;
    logic                 bnd_s;

    // A boundary is the count arriving at zero from a non-zero value: this
    // catches the normal wrap and an upstream counter reset, while a counter
    // parked at zero yields only the first one.
    assign bnd_s = (cnt_in == ZERO_C) && (cnt_d_r != ZERO_C);

    // Next-state, per-period counter and parameter-load decode.
    always_comb begin
        next_state_s   = state_r;
        per_cnt_next_s = per_cnt_r;
        load_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (nburst != ZERO_B)) begin
                    next_state_s   = ST_ARM;
                    load_s         = 1'b1;
                    per_cnt_next_s = ZERO_B;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else if (bnd_s) begin
                    next_state_s   = ST_RUN;
                    per_cnt_next_s = ZERO_B;
                end else begin
                    next_state_s = ST_ARM;
                end
            end
            ST_RUN: begin
                // stop wins over a coincident boundary
                if (stop) begin
                    next_state_s = ST_IDLE;
                end else if (bnd_s) begin
                    if (per_cnt_r == (nburst_r - ONE_B)) begin
                        next_state_s   = ST_DONE;
                        per_cnt_next_s = nburst_r;
                    end else begin
                        next_state_s   = ST_RUN;
                        per_cnt_next_s = per_cnt_r + ONE_B;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // PWM decision for the coming cycle; the compare is widened by one bit so
    // that a duty of 2**CNT_W keeps the output high for the whole period.
    always_comb begin
        pwm_next_s = 1'b0;
        if (next_state_s == ST_RUN) begin
            pwm_next_s = ({1'b0, cnt_in} < duty_r);
        end else begin
            pwm_next_s = 1'b0;
        end
    end

    // State, counter delay, latched burst parameters and PWM register.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r   <= ST_IDLE;
            cnt_d_r   <= ZERO_C;
            duty_r    <= {(CNT_W+1){1'b0}};
            nburst_r  <= ZERO_B;
            per_cnt_r <= ZERO_B;
            pwm_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_d_r   <= cnt_in;
            per_cnt_r <= per_cnt_next_s;
            pwm_r     <= pwm_next_s;
            if (load_s) begin
                duty_r   <= duty;
                nburst_r <= nburst;
            end
        end
    end

    assign pwm_out = pwm_r;
    assign busy    = (state_r == ST_ARM) || (state_r == ST_RUN);
    assign done    = (state_r == ST_DONE);
    assign per_cnt = per_cnt_r;

endmodule

// File: tb/tb_pwm_burst_gen.sv
// Self-checking bench for pwm_burst_gen: directed scenarios plus a random
// phase, all compared every cycle against a burst-level reference model that
// counts boundaries since the burst was armed.
module tb_pwm_burst_gen;

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic [4:0] duty = 5'd0;
    logic [7:0] nburst = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pwm_out;
    logic       busy;
    logic       done;
    logic [7:0] per_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit hold = 1'b0;
    int hi_cnt = 0;
    int done_cnt = 0;

    pwm_burst_gen #(.CNT_W(4), .BURST_W(8)) dut (
        .clk(clk), .rs(rs), .cnt_in(cnt_in), .duty(duty), .nburst(nburst),
        .start(start), .stop(stop), .pwm_out(pwm_out), .busy(busy),
        .done(done), .per_cnt(per_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is "armed" from an accepted start; m_bnds
    // counts boundaries seen since then. Boundary 1 opens period 1, boundary
    // n+1 closes period n and completes the burst.
    bit m_armed = 1'b0;
    bit m_done = 1'b0;
    bit m_pwm = 1'b0;
    int m_bnds = 0;
    int m_per = 0;
    int m_duty = 0;
    int m_n = 0;
    int m_prev = 0;

    always @(posedge clk) begin
        bit b;
        bit was_done;
        b = (int'(cnt_in) == 0) && (m_prev != 0);
        was_done = m_done;
        m_done = 1'b0;
        if (rs) begin
            m_armed = 1'b0; m_bnds = 0; m_per = 0; m_duty = 0; m_n = 0;
            m_pwm = 1'b0; m_prev = 0;
        end else begin
            if (m_armed) begin
                if (stop) begin
                    m_armed = 1'b0;
                end else if (b) begin
                    m_bnds++;
                    if (m_bnds == m_n + 1) begin
                        m_armed = 1'b0;
                        m_done = 1'b1;
                        m_per = m_n;
                    end else begin
                        m_per = m_bnds - 1;
                    end
                end
            end else if (start && nburst != 8'd0 && !was_done) begin
                m_armed = 1'b1; m_bnds = 0; m_per = 0;
                m_duty = int'(duty); m_n = int'(nburst);
            end
            m_pwm = m_armed && (m_bnds >= 1) && (int'(cnt_in) < m_duty);
            m_prev = int'(cnt_in);
        end
    end

    // Per-cycle comparison against the model, plus event counters for the
    // hand-computed scenario checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_out", int'(pwm_out), int'(m_pwm));
            check("busy", int'(busy), int'(m_armed));
            check("done", int'(done), int'(m_done));
            check("per_cnt", int'(per_cnt), m_per);
        end
        if (pwm_out === 1'b1) hi_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Apply start/stop for one edge, then advance the upstream counter.
    task automatic step(input logic st, input logic sp);
        start = st;
        stop = sp;
        @(posedge clk);
        #2;
        start = 1'b0;
        stop = 1'b0;
        if (!hold) cnt_in = cnt_in + 4'd1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 20 && int'(cnt_in) != v; i++) step(1'b0, 1'b0);
        check("wait_cnt", int'(cnt_in), v);
    endtask

    task automatic clr;
        hi_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        rs = 1'b1;
        steps(2);
        chk_en = 1'b1;
        rs = 1'b0;
        steps(3);

        // Test 1: reset in the middle of a running burst
        duty = 5'd8; nburst = 8'd3;
        step(1'b1, 1'b0);
        for (int i = 0; i < 40 && pwm_out !== 1'b1; i++) step(1'b0, 1'b0);
        check("t1_running", int'(busy), 1);
        steps(3);
        rs = 1'b1;
        step(1'b0, 1'b0);
        rs = 1'b0;
        check("t1_rst_pwm", int'(pwm_out), 0);
        check("t1_rst_busy", int'(busy), 0);
        check("t1_rst_done", int'(done), 0);
        check("t1_rst_per", int'(per_cnt), 0);
        clr();
        steps(20);
        check("t1_stay_idle", int'(busy), 0);
        check("t1_no_done", done_cnt, 0);

        // Test 2: basic burst, start while cnt_in = 5
        duty = 5'd4; nburst = 8'd2;
        wait_cnt(5);
        clr();
        step(1'b1, 1'b0);
        steps(50);
        check("t2_hi_cycles", hi_cnt, 8);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_per_cnt", int'(per_cnt), 2);
        check("t2_busy_low", int'(busy), 0);

        // Test 3: duty limits
        duty = 5'd0; nburst = 8'd1;
        clr();
        step(1'b1, 1'b0);
        steps(40);
        check("t3_duty0_hi", hi_cnt, 0);
        check("t3_duty0_done", done_cnt, 1);
        duty = 5'd16;
        clr();
        step(1'b1, 1'b0);
        steps(40);
        check("t3_duty16_hi", hi_cnt, 16);
        check("t3_duty16_done", done_cnt, 1);

        // Test 4: stop mid period 2, then stop on a boundary cycle
        duty = 5'd8; nburst = 8'd5;
        clr();
        step(1'b1, 1'b0);
        for (int i = 0; i < 50 && per_cnt != 8'd1; i++) step(1'b0, 1'b0);
        wait_cnt(6);
        step(1'b0, 1'b1);
        check("t4_stop_pwm", int'(pwm_out), 0);
        check("t4_stop_busy", int'(busy), 0);
        check("t4_stop_per", int'(per_cnt), 1);
        steps(20);
        check("t4_no_done", done_cnt, 0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 50 && per_cnt != 8'd1; i++) step(1'b0, 1'b0);
        wait_cnt(0);
        step(1'b0, 1'b1);
        check("t4_bnd_stop_busy", int'(busy), 0);
        steps(20);
        check("t4_bnd_no_done", done_cnt, 0);

        // Test 5: ignored starts
        nburst = 8'd0;
        step(1'b1, 1'b0);
        steps(20);
        check("t5_nburst0_busy", int'(busy), 0);
        duty = 5'd4; nburst = 8'd2;
        clr();
        step(1'b1, 1'b0);
        for (int i = 0; i < 30 && pwm_out !== 1'b1; i++) step(1'b0, 1'b0);
        duty = 5'd12; nburst = 8'd7;
        step(1'b1, 1'b0);
        steps(50);
        check("t5_old_duty_hi", hi_cnt, 8);
        check("t5_old_n_done", done_cnt, 1);
        check("t5_old_n_per", int'(per_cnt), 2);

        // Test 6: upstream counter reset to 0 while armed, then held at 0
        duty = 5'd4; nburst = 8'd1;
        wait_cnt(3);
        clr();
        step(1'b1, 1'b0);
        wait_cnt(9);
        step(1'b0, 1'b0);
        cnt_in = 4'd0;
        hold = 1'b1;
        steps(20);
        check("t6_running", int'(busy), 1);
        check("t6_pwm_held", int'(pwm_out), 1);
        check("t6_no_extra_bnd", done_cnt, 0);
        hold = 1'b0;
        steps(20);
        check("t6_done", done_cnt, 1);

        // Random phase
        for (int i = 0; i < 2500; i++) begin
            logic st;
            logic sp;
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 59) == 0);
            duty = 5'($urandom_range(0, 16));
            nburst = 8'($urandom_range(0, 3));
            rs = ($urandom_range(0, 299) == 0);
            step(st, sp);
            rs = 1'b0;
            if ($urandom_range(0, 149) == 0) cnt_in = 4'($urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
